// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage that feeds the IF/ID pipeline register. It owns the
// PC and keeps at most one fetch outstanding to instruction memory over a
// req/ack handshake. Returned instructions are buffered, together with their
// addresses, in a small FIFO. Redirect flushes the FIFO and retargets the PC.
// Stall holds the head entry in place. When the buffer is empty the stage
// presents a NOP (32'h00000013) at address 0.
//
// Parameters
//   RESET_PC    first PC fetched after reset
//   FIFO_DEPTH  fetch buffer entries (power of two, 2..8)
//
// Ports
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   redirect_valid   flush the buffer and redirect fetch this cycle
//   redirect_pc      new fetch target (word aligned)
//   stall            downstream not accepting; head entry held
//   imem_req         fetch request to instruction memory
//   imem_addr        fetch address
//   imem_ack         request accepted, imem_rdata valid this cycle
//   imem_rdata       fetched instruction
//   fetch_valid      buffer head valid
//   fetch_instr      head instruction, NOP when not valid
//   fetch_addr       head address, 0 when not valid
//
// Optional feature (macro IFETCH_PERF_EN)
//   perf_kill_cnt    responses discarded because of a redirect
//   perf_empty_cnt   FETCH/KILL cycles with an empty buffer and no stall
// -----------------------------------------------------------------------------
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] fetch_instr,
   output logic [31:0] fetch_addr
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_kill_cnt,
   output logic [31:0] perf_empty_cnt
`endif
);

   localparam int             PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [31:0]    NOP     = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      KILL  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic [31:0]    kill_addr_q, kill_addr_d;
   logic [PTR_W:0] count_q;
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;

   logic [31:0]    instr_buf [FIFO_DEPTH];
   logic [31:0]    addr_buf  [FIFO_DEPTH];

   logic           has_room;
   logic           xfer;
   logic           push;
   logic           pop;

   assign has_room    = (count_q < DEPTH_C);
   assign xfer        = imem_req && imem_ack;
   assign push        = (state_q == FETCH) && xfer && !redirect_valid;
   assign fetch_valid = (count_q != '0);
   assign pop         = fetch_valid && !stall && !redirect_valid;

   assign fetch_instr = fetch_valid ? instr_buf[rd_ptr_q] : NOP;
   assign fetch_addr  = fetch_valid ? addr_buf[rd_ptr_q]  : 32'h0000_0000;

   // Next-state, PC update and memory-side outputs.
   // In KILL the request for the abandoned address must stay stable until
   // memory acks it, so that address is held separately from the new PC.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_addr_d = kill_addr_q;
      imem_req    = 1'b0;
      imem_addr   = pc_q;
      case (state_q)
         BOOT: begin
            state_d = FETCH;
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
         end
         FETCH: begin
            imem_req = has_room;
            if (redirect_valid) begin
               pc_d = redirect_pc;
               if (has_room && !imem_ack) begin
                  state_d     = KILL;
                  kill_addr_d = pc_q;
               end
            end else if (has_room && imem_ack) begin
               pc_d = pc_q + 32'd4;
            end
         end
         KILL: begin
            imem_req  = 1'b1;
            imem_addr = kill_addr_q;
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
            if (imem_ack) begin
               state_d = FETCH;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         kill_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_addr_q <= kill_addr_d;
      end
   end

   // Buffer occupancy and pointers. A redirect empties the buffer outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else if (redirect_valid) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
            2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Buffer storage; contents are qualified by count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_buf[wr_ptr_q] <= imem_rdata;
         addr_buf[wr_ptr_q]  <= pc_q;
      end
   end

`ifdef IFETCH_PERF_EN
   logic kill_evt;
   logic empty_evt;

   assign kill_evt  = ((state_q == FETCH) && xfer && redirect_valid) ||
                      ((state_q == KILL) && imem_ack);
   assign empty_evt = ((state_q == FETCH) || (state_q == KILL)) &&
                      !fetch_valid && !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_kill_cnt  <= 32'd0;
         perf_empty_cnt <= 32'd0;
      end else begin
         if (kill_evt) begin
            perf_kill_cnt <= perf_kill_cnt + 32'd1;
         end
         if (empty_evt) begin
            perf_empty_cnt <= perf_empty_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed bench for ifetch_unit. dut0 uses the default RESET_PC. Its memory
// handshake, stall and redirect are driven here. dut1 starts at 0xFFFFFFF8.
// Its ack is tied high so that the PC wrap can be observed. Both memories
// return the fetch address as the instruction word.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_addr;

   logic        w_req;
   logic [31:0] w_addr;
   logic [31:0] w_rdata;
   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_faddr;

   int n_cmp;
   int n_err;

   assign imem_rdata = imem_addr;
   assign w_rdata    = w_addr;

   ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut0 (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall          (stall),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .fetch_valid    (fetch_valid),
      .fetch_instr    (fetch_instr),
      .fetch_addr     (fetch_addr)
   );

   ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut1 (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0000_0000),
      .stall          (1'b0),
      .imem_req       (w_req),
      .imem_addr      (w_addr),
      .imem_ack       (1'b1),
      .imem_rdata     (w_rdata),
      .fetch_valid    (w_valid),
      .fetch_instr    (w_instr),
      .fetch_addr     (w_faddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_state();
      check("rst_req",    {31'd0, imem_req},    32'd0);
      check("rst_addr",   imem_addr,            32'h0000_0000);
      check("rst_valid",  {31'd0, fetch_valid}, 32'd0);
      check("rst_instr",  fetch_instr,          NOP);
      check("rst_faddr",  fetch_addr,           32'h0000_0000);
      check("rst1_req",   {31'd0, w_req},       32'd0);
      check("rst1_valid", {31'd0, w_valid},     32'd0);
      check("rst1_instr", w_instr,              NOP);
      check("rst1_faddr", w_faddr,              32'h0000_0000);
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      rst            = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_ack       = 1'b1;

      @(negedge clk);
      check_reset_state();
      rst = 1'b0;

      // BOOT cycle done: request raised at RESET_PC, buffer still empty
      @(negedge clk);
      check("boot_req",   {31'd0, imem_req},    32'd1);
      check("boot_addr",  imem_addr,            32'h0000_0000);
      check("boot_valid", {31'd0, fetch_valid}, 32'd0);

      // Zero-wait streaming; dut1 wraps past 0xFFFFFFFC
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("str_valid", {31'd0, fetch_valid}, 32'd1);
         check("str_addr",  fetch_addr,  32'(4 * i));
         check("str_instr", fetch_instr, 32'(4 * i));
         check("wrap_addr", w_faddr,     32'hFFFF_FFF8 + 32'(4 * i));
         check("wrap_instr", w_instr,    32'hFFFF_FFF8 + 32'(4 * i));
      end

      // Stall: buffer fills, request drops, head frozen at 12
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("stl_addr", fetch_addr, 32'h0000_000C);
         check("stl_req",  {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;

      // Release: pop from full buffer, request back next cycle, no gap
      @(negedge clk);
      check("rel_addr0", fetch_addr, 32'h0000_0010);
      check("rel_req",   {31'd0, imem_req}, 32'd1);
      check("rel_iaddr", imem_addr, 32'h0000_0014);
      for (int i = 1; i < 3; i++) begin
         @(negedge clk);
         check("rel_valid", {31'd0, fetch_valid}, 32'd1);
         check("rel_addr",  fetch_addr, 32'h0000_0010 + 32'(4 * i));
      end

      // Delayed ack with redirect while the request is pending
      imem_ack = 1'b0;
      @(negedge clk);
      check("kil_valid0", {31'd0, fetch_valid}, 32'd0);
      check("kil_req0",   {31'd0, imem_req},    32'd1);
      check("kil_addr0",  imem_addr,            32'h0000_001C);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("kil_addr1",  imem_addr,            32'h0000_001C);
      check("kil_req1",   {31'd0, imem_req},    32'd1);
      check("kil_valid1", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
      check("kil_addr2",  imem_addr,            32'h0000_001C);
      check("kil_valid2", {31'd0, fetch_valid}, 32'd0);
      imem_ack = 1'b1;
      @(negedge clk);
      check("kil_addr3",  imem_addr,            32'h0000_0100);
      check("kil_valid3", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
      check("kil_valid4", {31'd0, fetch_valid}, 32'd1);
      check("kil_faddr",  fetch_addr,           32'h0000_0100);
      check("kil_instr",  fetch_instr,          32'h0000_0100);

      // Redirect to 0x10, then redirect to 0x200 in the cycle 0x10 is acked
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0010;
      @(negedge clk);
      check("rd1_valid", {31'd0, fetch_valid}, 32'd0);
      check("rd1_addr",  imem_addr,            32'h0000_0010);
      redirect_pc = 32'h0000_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("rd2_valid", {31'd0, fetch_valid}, 32'd0);
      check("rd2_addr",  imem_addr,            32'h0000_0200);
      @(negedge clk);
      check("rd3_valid", {31'd0, fetch_valid}, 32'd1);
      check("rd3_faddr", fetch_addr,           32'h0000_0200);
      check("rd3_instr", fetch_instr,          32'h0000_0200);

      // Enter KILL, then reset asynchronously while the ack is still pending
      imem_ack = 1'b0;
      @(negedge clk);
      check("pk_addr0", imem_addr, 32'h0000_0204);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      @(negedge clk);
      redirect_valid = 1'b0;
      check("pk_addr1", imem_addr, 32'h0000_0204);
      #1 rst = 1'b1;
      #1 check_reset_state();
      @(negedge clk);
      rst      = 1'b0;
      imem_ack = 1'b1;
      @(negedge clk);
      check("rr_req",   {31'd0, imem_req},    32'd1);
      check("rr_addr",  imem_addr,            32'h0000_0000);
      check("rr_valid", {31'd0, fetch_valid}, 32'd0);
      @(negedge clk);
      check("rr_valid1", {31'd0, fetch_valid}, 32'd1);
      check("rr_faddr",  fetch_addr,           32'h0000_0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
